// File: rtl/wb_port_arbiter_if.sv
// Write-back request, scoreboard query and register-file write bundle
// shared between the write-back requesters and wb_port_arbiter.
interface wb_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              Wen;
    logic [ADDR_W-1:0] Rd_addr;
    logic [DATA_W-1:0] write_data;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output issue_valid, issue_rd,
        output rs1_addr, rs2_addr,
        input  a_ready, b_ready,
        input  rs1_busy, rs2_busy,
        input  Wen, Rd_addr, write_data
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  issue_valid, issue_rd,
        input  rs1_addr, rs2_addr,
        output a_ready, b_ready,
        output rs1_busy, rs2_busy,
        output Wen, Rd_addr, write_data
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-port write-back arbiter with registered register-file write
// and per-register pending-write scoreboard.
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [NREG-1:0] X0_MASK = ~{{(NREG-1){1'b0}}, 1'b1};

    logic              r_prio_a;
    logic              r_wen;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [NREG-1:0]   r_busy;

    logic              w_prio_a_nxt;
    logic              w_wen_nxt;
    logic [ADDR_W-1:0] w_rd_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [NREG-1:0]   w_busy_nxt;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;

    logic w_a_ready;
    logic w_b_ready;
    logic w_a_fire;
    logic w_b_fire;
    logic w_contend;

    assign w_a_ready = !(bus.b_valid && !r_prio_a);
    assign w_b_ready = !(bus.a_valid && r_prio_a);
    assign w_a_fire  = bus.a_valid && w_a_ready;
    assign w_b_fire  = bus.b_valid && w_b_ready;
    assign w_contend = bus.a_valid && bus.b_valid;

    // Contention hands priority to whichever side just lost.
    always_comb begin
        w_prio_a_nxt = r_prio_a;
        if (w_contend) begin
            w_prio_a_nxt = !r_prio_a;
        end
    end

    always_comb begin
        w_wen_nxt  = 1'b0;
        w_rd_nxt   = r_rd;
        w_data_nxt = r_data;
        if (w_a_fire) begin
            w_wen_nxt  = (bus.a_rd != '0);
            w_rd_nxt   = bus.a_rd;
            w_data_nxt = bus.a_data;
        end else if (w_b_fire) begin
            w_wen_nxt  = (bus.b_rd != '0);
            w_rd_nxt   = bus.b_rd;
            w_data_nxt = bus.b_data;
        end
    end

    // Set is applied after clear so a re-issue keeps the register busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.issue_valid) begin
            w_set[bus.issue_rd] = 1'b1;
        end
        if (r_wen) begin
            w_clr[r_rd] = 1'b1;
        end
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & X0_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_a <= 1'b1;
            r_wen    <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_busy   <= '0;
        end else begin
            r_prio_a <= w_prio_a_nxt;
            r_wen    <= w_wen_nxt;
            r_rd     <= w_rd_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.a_ready    = w_a_ready;
    assign bus.b_ready    = w_b_ready;
    assign bus.Wen        = r_wen;
    assign bus.Rd_addr    = r_rd;
    assign bus.write_data = r_data;
    assign bus.rs1_busy   = r_busy[bus.rs1_addr];
    assign bus.rs2_busy   = r_busy[bus.rs2_addr];
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(64)) bus ();

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_valid     = 1'b0;
        bus.a_rd        = '0;
        bus.a_data      = '0;
        bus.b_valid     = 1'b0;
        bus.b_rd        = '0;
        bus.b_data      = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Behavioural model: grant rules, priority memory, write register
    // and a busy table indexed by register number.
    bit          m_prio = 1'b1;
    bit          m_wen  = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [63:0] m_data = '0;
    bit          m_busy [32];
    bit          m_ga, m_gb, m_old_wen;
    logic [4:0]  m_old_rd;

    initial foreach (m_busy[i]) m_busy[i] = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prio = 1'b1;
            m_wen  = 1'b0;
            m_rd   = '0;
            m_data = '0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            m_ga = bus.a_valid && (!bus.b_valid || m_prio);
            m_gb = bus.b_valid && !m_ga;
            m_old_wen = m_wen;
            m_old_rd  = m_rd;
            if (bus.a_valid && bus.b_valid) m_prio = m_gb;
            if (m_ga) begin
                m_wen  = (bus.a_rd != 0);
                m_rd   = bus.a_rd;
                m_data = bus.a_data;
            end else if (m_gb) begin
                m_wen  = (bus.b_rd != 0);
                m_rd   = bus.b_rd;
                m_data = bus.b_data;
            end else begin
                m_wen = 1'b0;
            end
            if (m_old_wen) m_busy[m_old_rd] = 1'b0;
            if (bus.issue_valid && bus.issue_rd != 0)
                m_busy[bus.issue_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.a_valid)
                chk("m_a_ready", bus.a_ready, !bus.b_valid || m_prio);
            if (bus.b_valid)
                chk("m_b_ready", bus.b_ready, !bus.a_valid || !m_prio);
            chk("m_wen", bus.Wen, m_wen);
            chk("m_rd_addr", bus.Rd_addr, m_rd);
            chk("m_wdata", bus.write_data, m_data);
            chk("m_rs1_busy", bus.rs1_busy, m_busy[bus.rs1_addr]);
            chk("m_rs2_busy", bus.rs2_busy, m_busy[bus.rs2_addr]);
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst_wen", bus.Wen, 0);
        chk("rst_rd_addr", bus.Rd_addr, 0);
        chk("rst_wdata", bus.write_data, 0);
        chk("rst_rs1_busy", bus.rs1_busy, 0);
        chk("rst_a_ready_idle", bus.a_ready, 1);
        chk("rst_b_ready_idle", bus.b_ready, 1);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        chk("rst_a_ready_both", bus.a_ready, 1);
        chk("rst_b_ready_both", bus.b_ready, 0);
        clear_inputs();
        #1;
        rst = 1'b0;
        step();

        // single ALU write
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 64'h1234;
        @(negedge clk);
        chk("t1_a_ready", bus.a_ready, 1);
        step();
        bus.a_valid = 1'b0;
        @(negedge clk);
        chk("t1_wen", bus.Wen, 1);
        chk("t1_rd_addr", bus.Rd_addr, 5);
        chk("t1_wdata", bus.write_data, 64'h1234);
        step();
        @(negedge clk);
        chk("t1_wen_off", bus.Wen, 0);

        // sustained contention alternates A, B, A, B
        do_reset();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd3;
        bus.a_data  = 64'hA;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd4;
        bus.b_data  = 64'hB;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                bus.a_valid = 1'b0;
                bus.b_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 4) begin
                chk("t2_a_ready", bus.a_ready, (c % 2) == 0);
                chk("t2_b_ready", bus.b_ready, (c % 2) == 1);
            end
            if (c >= 1) begin
                chk("t2_wen", bus.Wen, 1);
                chk("t2_rd_addr", bus.Rd_addr, (c % 2) ? 3 : 4);
            end
            step();
        end

        // issue x7, load writes x7 later
        do_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.rs1_addr    = 5'd7;
        @(negedge clk);
        chk("t3_busy_c0", bus.rs1_busy, 0);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t3_busy_c1", bus.rs1_busy, 1);
        step();
        @(negedge clk);
        chk("t3_busy_c2", bus.rs1_busy, 1);
        step();
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd7;
        bus.b_data  = 64'h77;
        @(negedge clk);
        chk("t3_b_ready", bus.b_ready, 1);
        step();
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("t3_wen_c4", bus.Wen, 1);
        chk("t3_busy_c4", bus.rs1_busy, 1);
        step();
        @(negedge clk);
        chk("t3_busy_c5", bus.rs1_busy, 0);

        // writes and issues to x0
        do_reset();
        bus.a_valid     = 1'b1;
        bus.a_rd        = 5'd0;
        bus.a_data      = 64'hFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        bus.rs2_addr    = 5'd0;
        @(negedge clk);
        chk("t4_a_ready", bus.a_ready, 1);
        step();
        clear_inputs();
        @(negedge clk);
        chk("t4_wen", bus.Wen, 0);
        chk("t4_rs2_busy", bus.rs2_busy, 0);

        // simultaneous clear and set of x9
        do_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.rs1_addr    = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        bus.a_valid     = 1'b1;
        bus.a_rd        = 5'd9;
        bus.a_data      = 64'h99;
        step();
        bus.a_valid     = 1'b0;
        bus.issue_valid = 1'b1;
        @(negedge clk);
        chk("t5_wen", bus.Wen, 1);
        chk("t5_rd_addr", bus.Rd_addr, 9);
        step();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_c3", bus.rs1_busy, 1);
        step();
        @(negedge clk);
        chk("t5_busy_c4", bus.rs1_busy, 1);

        // asynchronous reset mid-cycle
        do_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        bus.rs1_addr    = 5'd12;
        step();
        bus.issue_valid = 1'b0;
        bus.a_valid     = 1'b1;
        bus.a_rd        = 5'd12;
        bus.a_data      = 64'hC0DE;
        @(negedge clk);
        chk("t6_busy_pre", bus.rs1_busy, 1);
        step();
        bus.a_valid = 1'b0;
        #1;
        chk("t6_wen_pre", bus.Wen, 1);
        chk("t6_busy_mid", bus.rs1_busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_wen_async", bus.Wen, 0);
        chk("t6_busy_async", bus.rs1_busy, 0);
        step();
        #3;
        rst = 1'b0;
        step();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd1;
        bus.a_data  = 64'h1;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd2;
        bus.b_data  = 64'h2;
        @(negedge clk);
        chk("t6_a_wins", bus.a_ready, 1);
        chk("t6_b_loses", bus.b_ready, 0);
        step();
        clear_inputs();
        @(negedge clk);
        chk("t6_rd_addr", bus.Rd_addr, 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back arbiter and scoreboard for the 64-bit, 32-entry integer register file. It shares the register file's single write port between two write-back requesters: port A (ALU results) and port B (load data). It registers the winning write onto the register file's `Wen`/`Rd_addr`/`write_data` inputs. It also keeps per-register pending-write (busy) bits, which the issue stage queries to stall on RAW hazards.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width. The block tracks 2^ADDR_W registers.
- `DATA_W`, default 64: write data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `a_valid`  in  1  ALU write-back request.
- `a_ready`  out  1  ALU request accepted this cycle.
- `a_rd`  in  ADDR_W  ALU destination register.
- `a_data`  in  DATA_W  ALU result.
- `b_valid`  in  1  load write-back request.
- `b_ready`  out  1  load request accepted this cycle.
- `b_rd`  in  ADDR_W  load destination register.
- `b_data`  in  DATA_W  load data.
- `issue_valid`  in  1  an instruction with a destination issues this cycle.
- `issue_rd`  in  ADDR_W  destination of the issuing instruction.
- `rs1_addr`, `rs2_addr`  in  ADDR_W  source registers queried by issue.
- `rs1_busy`, `rs2_busy`  out  1  queried register has a pending write.
- `Wen`  out  1  register-file write enable.
- `Rd_addr`  out  ADDR_W  register-file write address.
- `write_data`  out  DATA_W  register-file write data.

## Operation
Handshake:
- A transfer occurs when `x_valid && x_ready`.
- A requester holds valid, rd and data stable until it sees ready.
- The register-file write port has no backpressure, so exactly one request can be accepted per cycle.

Arbitration:
- The arbiter holds one state bit, `prio_a`.
- `a_ready = !(b_valid && !prio_a)`.
- `b_ready = !(a_valid && prio_a)`.
- Ready signals are combinational from the valids and `prio_a`.
- With only one valid asserted, that requester is granted.
- On a contention cycle (both valid):
  - The side favoured by `prio_a` wins.
  - At the edge, `prio_a` flips to favour the loser.
- `prio_a` is unchanged in non-contention cycles.

Output register:
- On an accepted transfer, `Rd_addr`/`write_data` load the winner's rd/data at the edge.
- `Wen` loads 1 if rd != 0, and 0 if rd == 0. A write to x0 is accepted but never written.
- In a cycle with no transfer, `Wen` loads 0 and `Rd_addr`/`write_data` hold their values.

Scoreboard (`busy[2^ADDR_W-1:0]`):
- Set: `issue_valid && issue_rd != 0` sets `busy[issue_rd]` at the edge.
- Clear: `Wen == 1` clears `busy[Rd_addr]` at the edge. The clear lands on the same edge at which the register file commits the write.
- Same register set and cleared on the same edge: set wins, because the new instruction owns the register.
- `busy[0]` is constant 0.
- `rs1_busy = busy[rs1_addr]` and `rs2_busy = busy[rs2_addr]`, combinational.

The block does not check that write-backs match issued instructions. A write-back to a non-busy register is performed normally.

## Timing
- Reset: `Wen=0`, `Rd_addr=0`, `write_data=0`, all `busy=0`, `prio_a=1` (A wins the first contention).
- Reset is asynchronous. When it is asserted mid-operation, it immediately drops `Wen` and clears the scoreboard. Any in-flight output write is discarded.
- While `rst` is high, `a_ready` and `b_ready` still follow their equations, but no state changes.
- Latency for a transfer in cycle N:
  - `Wen`/`Rd_addr`/`write_data` are valid during cycle N+1.
  - The register file commits at the end of cycle N+1.
  - The busy bit reads 0 from cycle N+2 onward, the same cycle the register file returns the new value.
- Issue at cycle N: the busy bit reads 1 from cycle N+1.
- Throughput is one write per cycle. Under sustained contention, A and B alternate grants.
- Back-to-back writes to the same rd from A then B are committed in acceptance order.

## Test plan
- Reset, then `a_valid=1`, `a_rd=5`, `a_data=0x1234`, `b_valid=0` at cycle 0:
  - `a_ready=1` in cycle 0.
  - Cycle 1: `Wen=1`, `Rd_addr=5`, `write_data=0x1234`.
  - Cycle 2: `Wen=0`.
- A (rd 3, data 0xA) and B (rd 4, data 0xB) both held valid for 4 cycles from reset:
  - Grants are A, B, A, B.
  - `Wen` writes x3, x4, x3, x4 in cycles 1-4.
  - Each side sees ready on alternate cycles.
- `issue_valid=1`, `issue_rd=7` at cycle 0; `rs1_addr=7` throughout:
  - `rs1_busy=1` from cycle 1.
  - B writes rd 7 at cycle 3, so `Wen` is high in cycle 4 and `rs1_busy=0` from cycle 5.
- A writes rd 0 with data 0xFFFF:
  - `a_ready=1`, and `Wen` stays 0 in the following cycle.
  - Issuing rd 0 leaves `rs2_busy=0` for `rs2_addr=0`.
- Busy x9 with `Wen=1`/`Rd_addr=9` in the same cycle as `issue_valid=1`/`issue_rd=9`: `busy[9]` remains 1 after the edge.
- `rst` pulsed mid-cycle while `Wen=1` and x12 is busy:
  - `Wen` drops to 0 immediately, without waiting for a clock edge.
  - `rs1_busy` for x12 reads 0.
  - The next contention is won by A.
